// File: rtl/dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_cache_ctrl
// Description : Direct-mapped, one-word-per-line data cache controller for a
//               CPU memory stage. Loads allocate on miss, stores are
//               write-through / no-allocate. Flush invalidates every line.
//               Optional misalignment check enabled by defining
//               DMEM_ALIGN_CHECK_EN (odd byte address -> err + done pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_cache_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LINES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WRT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              flush_pend_q, flush_pend_d;
  logic              line_we;
  logic [DATA_W-1:0] line_wdata;

  // Request-side decode uses the live address; the completion side uses the
  // registered memory address so a line update never depends on the requester.
  logic [IDX_W-1:0] w_req_idx, w_mem_idx;
  logic [TAG_W-1:0] w_req_tag, w_mem_tag;
  logic             w_req_hit, w_mem_hit;
  logic             w_accept;
  logic             w_flush_req;
  logic             w_misaligned;

  assign w_req_idx   = addr[IDX_W:1];
  assign w_req_tag   = addr[ADDR_W-1:IDX_W+1];
  assign w_mem_idx   = mem_addr_q[IDX_W:1];
  assign w_mem_tag   = mem_addr_q[ADDR_W-1:IDX_W+1];
  assign w_req_hit   = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
  assign w_mem_hit   = valid_q[w_mem_idx] && (tag_q[w_mem_idx] == w_mem_tag);
  // No request is taken in the cycle a done pulse is being driven.
  assign w_accept    = (state_q == S_IDLE) && !done_q;
  assign w_flush_req = flush | flush_pend_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  assign w_misaligned = addr[0];

  // Error flag pulses alongside done for an odd-address request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= w_accept && !w_flush_req && en && w_misaligned;
    end
  end

  assign err = err_q;
`else
  logic w_unused_addr0;

  assign w_unused_addr0 = addr[0];
  assign w_misaligned   = 1'b0;
  assign err            = 1'b0;
`endif

  // Next-state and registered-output computation for the controller FSM.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    flush_pend_d = flush_pend_q;
    line_we      = 1'b0;
    line_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (done_q) begin
          // Keep a flush raised during the done cycle for the next cycle.
          if (flush) flush_pend_d = 1'b1;
        end else if (w_flush_req) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
          done_d       = 1'b1;
        end else if (en) begin
          if (w_misaligned) begin
            done_d = 1'b1;
          end else if (!wr) begin
            if (w_req_hit) begin
              done_d  = 1'b1;
              rdata_d = data_q[w_req_idx];
            end else begin
              state_d    = S_FILL;
              mem_req_d  = 1'b1;
              mem_wr_d   = 1'b0;
              mem_addr_d = addr;
            end
          end else begin
            state_d     = S_WRT;
            mem_req_d   = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
          end
        end
      end
      S_FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          line_we              = 1'b1;
          line_wdata           = mem_rdata;
          valid_d[w_mem_idx]   = 1'b1;
          rdata_d              = mem_rdata;
          done_d               = 1'b1;
          mem_req_d            = 1'b0;
          state_d              = S_IDLE;
        end
      end
      S_WRT: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          // Write-through: refresh a resident copy, never allocate.
          if (w_mem_hit) begin
            line_we    = 1'b1;
            line_wdata = mem_wdata_q;
          end
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_wr_d  = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      busy_q       <= (state_d != S_IDLE);
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag/data storage; contents are qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[w_mem_idx]  <= w_mem_tag;
      data_q[w_mem_idx] <= line_wdata;
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
